csr_trap_unit: RTL and testbench
================================

# csr_trap_unit

Parametrised machine-mode CSR file and trap controller for the M-stage commit point of the in-order core. It holds the machine CSRs and performs CSRRW/CSRRS/CSRRC writes, ECALL/exception entry, MRET return and interrupt entry. It supports configurable XLEN, NIRQ platform interrupt lines with optional input synchronisers, vectored mtvec, and minstret. A taken event redirects fetch and flushes the pipeline in the same cycle the instruction is presented.

## Interface
- XLEN, 64, data/CSR width (32 or 64)
- NIRQ, 4, platform interrupt lines, cause 16+i, mie/mip bit 16+i (1..16)
- SYNC_IRQ, 1, 1 = two-flop synchroniser on all irq inputs, 0 = direct
- RESET_VEC, 'h8000_0000, reset value of mtvec (mode bits 0)
- HART_ID, 0, value read from mhartid
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- ra  in  12  CSR read address (combinational read port for D/E stage)
- rd  out  XLEN  CSR read data; unknown address reads 0
- commit_valid  in  1  instruction present at commit
- commit_pc  in  XLEN  its pc
- commit_kind  in  3  0 plain, 1 CSRRW, 2 CSRRS, 3 CSRRC, 4 MRET, 5 ECALL
- commit_csr  in  12  CSR destination address
- commit_wdata  in  XLEN  rs1 value or zero-extended zimm
- commit_exc  in  3  0 none, 1 instr-misalign, 2 illegal, 3 load-misalign, 4 store-misalign
- commit_tval  in  XLEN  faulting address/instruction for mtval
- stall  in  1  commit point held; no architectural update
- irq_timer, irq_soft, irq_ext  in  1 each  machine timer/software/external lines
- irq_plat  in  NIRQ  platform lines
- redirect  out  1  flush whole pipeline and refetch from redirect_pc
- redirect_pc  out  XLEN  target
- priv  out  2  current privilege (3 = M, 0 = U)

## Operation
- Implemented CSRs: mstatus, mie, mip, mtvec, mscratch, mepc, mcause, mtval, mcycle, minstret, mhartid (read-only). Writes to unknown or read-only addresses are ignored; no trap.
- mstatus write mask: MIE[3], MPIE[7], MPP[12:11]; other bits read 0. MPP WARL: written 1 or 2 stores 0.
- mie/mip implemented bits: 3, 7, 11, 16..16+NIRQ-1; others read 0. mip is read-only and reflects the synchronised lines.
- mtvec mode WARL: written mode 2 or 3 stores 0. mepc[1:0] read 0.
- The commit event is active when commit_valid && !stall. One event per cycle, in priority order:
  1. Exception (commit_exc≠0 or kind=ECALL). mcause: 0/2/4/6 for exc 1–4. ECALL mcause is 8 from U, 11 from M. commit_exc wins over ECALL. mtval = commit_tval for exc 1–4, 0 otherwise.
  2. Interrupt: mstatus.MIE && |(mip & mie). Cause priority: 11 > 3 > 7 > 16+i with the lowest i first. mcause MSB = 1. mtval = 0. The instruction is not executed.
  3. CSR op: new value is wdata (RW), old|wdata (RS) or old&~wdata (RC). RS/RC with wdata==0 performs no write. redirect_pc = pc+4.
  4. MRET: priv←MPP, MIE←MPIE, MPIE←1, MPP←0. redirect_pc = mepc.
- Trap entry (1, 2): mepc←commit_pc, MPIE←MIE, MIE←0, MPP←priv, priv←3. redirect_pc = mtvec base, or base + 4·cause for interrupts when mode = 1.
- mcycle increments every cycle. minstret increments on an active event with no trap. A CSR write to a counter in the same cycle takes precedence over the increment.
- The MRET target is taken from the current mepc; a CSR write in the same cycle is impossible.

## Timing
- redirect and redirect_pc are combinational from commit_* and registered state, valid in the same cycle. redirect = 0 whenever commit_valid=0, stall=1 or kind=plain with no trap.
- CSR and priv updates are visible on rd/priv the cycle after the event. rd has no internal bypass; the pipeline flush covers the hazard.
- irq-to-mip latency is 2 cycles with SYNC_IRQ=1 and 0 with SYNC_IRQ=0.
- While stall=1, only mcycle and the synchronisers advance. Pending interrupts wait until the next active event.
- Reset values: priv=3, mtvec=RESET_VEC, all other CSRs 0 (MIE=0), synchroniser flops 0. Reset mid-event discards the event.

## Test plan
- Reset, then read mtvec/mstatus/mcycle → RESET_VEC, 0, and mcycle = number of cycles since reset released; priv=3.
- CSRRW mtvec=0x100 at pc 0x40 → redirect=1, redirect_pc=0x44. Next cycle ra=mtvec reads 0x100. CSRRS mstatus with wdata=0 → no change.
- ECALL in U (after MRET with MPP=0) at pc 0x200 → mcause=8, mepc=0x200, priv=3, MPP=0, redirect_pc=mtvec.
- mtvec=0x101, MIE=1, mie[16+2]=1, pulse irq_plat[2] with SYNC_IRQ=1 → taken on the first commit ≥2 cycles later. mcause=MSB|18, redirect_pc=0x100+72.
- Simultaneous load-misalign, irq_ext enabled and a CSR op → exception wins: mcause=4, mtval=commit_tval, CSR unchanged.
- stall=1 with an interrupt pending for 5 cycles → no redirect and minstret unchanged. The interrupt is taken when stall drops.

Source files
------------

// File: rtl/csr_trap_unit.sv
// Machine-mode CSR file and trap controller at the commit point of the in-order core.
// Resolves at most one commit event per cycle (exception, interrupt, CSR op, MRET) and redirects fetch.
module csr_trap_unit #(
   parameter int          XLEN      = 64,
   parameter int          NIRQ      = 4,
   parameter int          SYNC_IRQ  = 1,
   parameter logic [63:0] RESET_VEC = 64'h8000_0000,
   parameter logic [63:0] HART_ID   = 64'h0
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [11:0]     ra,
   output logic [XLEN-1:0] rd,
   input  logic            commit_valid,
   input  logic [XLEN-1:0] commit_pc,
   input  logic [2:0]      commit_kind,
   input  logic [11:0]     commit_csr,
   input  logic [XLEN-1:0] commit_wdata,
   input  logic [2:0]      commit_exc,
   input  logic [XLEN-1:0] commit_tval,
   input  logic            stall,
   input  logic            irq_timer,
   input  logic            irq_soft,
   input  logic            irq_ext,
   input  logic [NIRQ-1:0] irq_plat,
   output logic            redirect,
   output logic [XLEN-1:0] redirect_pc,
   output logic [1:0]      priv
);

   localparam logic [11:0] A_MSTATUS  = 12'h300;
   localparam logic [11:0] A_MIE      = 12'h304;
   localparam logic [11:0] A_MTVEC    = 12'h305;
   localparam logic [11:0] A_MSCRATCH = 12'h340;
   localparam logic [11:0] A_MEPC     = 12'h341;
   localparam logic [11:0] A_MCAUSE   = 12'h342;
   localparam logic [11:0] A_MTVAL    = 12'h343;
   localparam logic [11:0] A_MIP      = 12'h344;
   localparam logic [11:0] A_MCYCLE   = 12'hB00;
   localparam logic [11:0] A_MINSTRET = 12'hB02;
   localparam logic [11:0] A_MHARTID  = 12'hF14;

   localparam logic [2:0] K_RW    = 3'd1;
   localparam logic [2:0] K_RS    = 3'd2;
   localparam logic [2:0] K_RC    = 3'd3;
   localparam logic [2:0] K_MRET  = 3'd4;
   localparam logic [2:0] K_ECALL = 3'd5;

   localparam logic [XLEN-1:0] IRQ_MASK = XLEN'((((64'd1 << NIRQ) - 64'd1) << 16) | 64'h888);

   typedef enum logic [2:0] {EV_NONE, EV_PLAIN, EV_CSR, EV_MRET, EV_EXC, EV_IRQ} event_t;

   logic            st_mie, st_mpie;
   logic [1:0]      st_mpp;
   logic [XLEN-3:0] mtvec_base;
   logic            mtvec_mode;
   logic [XLEN-1:0] mie_r, mscratch, mepc, mcause, mtval, mcycle, minstret;

   logic [NIRQ+2:0] irq_raw, irq_sync;
   logic [XLEN-1:0] mip_val, mstatus_val, mtvec_val, pend;
   logic [XLEN-1:0] csr_old, csr_new, trap_cause, trap_tval, trap_base;
   logic [4:0]      irq_cause;
   logic [3:0]      exc_cause;
   logic            csr_we;
   event_t          ev;

   assign irq_raw = {irq_plat, irq_ext, irq_timer, irq_soft};

   generate
      if (SYNC_IRQ != 0) begin : g_sync
         logic [NIRQ+2:0] meta, stable;
         always_ff @(posedge clk) begin
            if (reset) begin
               meta   <= '0;
               stable <= '0;
            end else begin
               meta   <= irq_raw;
               stable <= meta;
            end
         end
         assign irq_sync = stable;
      end else begin : g_direct
         assign irq_sync = irq_raw;
      end
   endgenerate

   always_comb begin
      mip_val            = '0;
      mip_val[3]         = irq_sync[0];
      mip_val[7]         = irq_sync[1];
      mip_val[11]        = irq_sync[2];
      mip_val[16 +: NIRQ] = irq_sync[3 +: NIRQ];
      mstatus_val        = '0;
      mstatus_val[3]     = st_mie;
      mstatus_val[7]     = st_mpie;
      mstatus_val[12:11] = st_mpp;
   end

   assign mtvec_val = {mtvec_base, 1'b0, mtvec_mode};
   assign trap_base = {mtvec_base, 2'b00};
   assign pend      = mip_val & mie_r;

   function automatic logic [XLEN-1:0] csr_read(input logic [11:0] a);
      case (a)
         A_MSTATUS:  return mstatus_val;
         A_MIE:      return mie_r;
         A_MIP:      return mip_val;
         A_MTVEC:    return mtvec_val;
         A_MSCRATCH: return mscratch;
         A_MEPC:     return mepc;
         A_MCAUSE:   return mcause;
         A_MTVAL:    return mtval;
         A_MCYCLE:   return mcycle;
         A_MINSTRET: return minstret;
         A_MHARTID:  return XLEN'(HART_ID);
         default:    return '0;
      endcase
   endfunction

   always_comb begin
      rd      = csr_read(ra);
      csr_old = csr_read(commit_csr);
   end

   // Later assignments win: platform lines (lowest index first) < 7 < 3 < 11.
   always_comb begin
      irq_cause = '0;
      for (int i = NIRQ - 1; i >= 0; i--) begin
         if (pend[16+i]) irq_cause = 5'(16 + i);
      end
      if (pend[7])  irq_cause = 5'd7;
      if (pend[3])  irq_cause = 5'd3;
      if (pend[11]) irq_cause = 5'd11;
   end

   always_comb begin
      ev = EV_NONE;
      if (commit_valid && !stall) begin
         if (commit_exc != 3'd0 || commit_kind == K_ECALL)             ev = EV_EXC;
         else if (st_mie && (pend != '0))                              ev = EV_IRQ;
         else if (commit_kind == K_RW || commit_kind == K_RS ||
                  commit_kind == K_RC)                                 ev = EV_CSR;
         else if (commit_kind == K_MRET)                               ev = EV_MRET;
         else                                                          ev = EV_PLAIN;
      end
   end

   always_comb begin
      exc_cause  = (commit_exc != 3'd0) ? {commit_exc - 3'd1, 1'b0}
                                        : ((priv == 2'd3) ? 4'd11 : 4'd8);
      trap_cause = (ev == EV_IRQ) ? ({1'b1, {(XLEN-1){1'b0}}} | XLEN'(irq_cause))
                                  : XLEN'(exc_cause);
      trap_tval  = (ev == EV_EXC && commit_exc != 3'd0) ? commit_tval : '0;
      case (commit_kind)
         K_RS:    csr_new = csr_old | commit_wdata;
         K_RC:    csr_new = csr_old & ~commit_wdata;
         default: csr_new = commit_wdata;
      endcase
      csr_we = (ev == EV_CSR) && (commit_kind == K_RW || commit_wdata != '0);
   end

   always_comb begin
      redirect    = 1'b0;
      redirect_pc = '0;
      case (ev)
         EV_EXC: begin
            redirect    = 1'b1;
            redirect_pc = trap_base;
         end
         EV_IRQ: begin
            redirect    = 1'b1;
            redirect_pc = mtvec_mode ? trap_base + (XLEN'(irq_cause) << 2) : trap_base;
         end
         EV_CSR: begin
            redirect    = 1'b1;
            redirect_pc = commit_pc + XLEN'(4);
         end
         EV_MRET: begin
            redirect    = 1'b1;
            redirect_pc = mepc;
         end
         default: ;
      endcase
   end

   // Counter increments come first so that a same-cycle CSR write to a counter overrides them.
   always_ff @(posedge clk) begin
      if (reset) begin
         priv       <= 2'd3;
         st_mie     <= 1'b0;
         st_mpie    <= 1'b0;
         st_mpp     <= 2'd0;
         mtvec_base <= RESET_VEC[XLEN-1:2];
         mtvec_mode <= 1'b0;
         mie_r      <= '0;
         mscratch   <= '0;
         mepc       <= '0;
         mcause     <= '0;
         mtval      <= '0;
         mcycle     <= '0;
         minstret   <= '0;
      end else begin
         mcycle <= mcycle + XLEN'(1);
         if (ev == EV_PLAIN || ev == EV_CSR || ev == EV_MRET) minstret <= minstret + XLEN'(1);
         case (ev)
            EV_EXC, EV_IRQ: begin
               mepc    <= {commit_pc[XLEN-1:2], 2'b00};
               mcause  <= trap_cause;
               mtval   <= trap_tval;
               st_mpie <= st_mie;
               st_mie  <= 1'b0;
               st_mpp  <= priv;
               priv    <= 2'd3;
            end
            EV_MRET: begin
               priv    <= st_mpp;
               st_mie  <= st_mpie;
               st_mpie <= 1'b1;
               st_mpp  <= 2'd0;
            end
            EV_CSR: begin
               if (csr_we) begin
                  case (commit_csr)
                     A_MSTATUS: begin
                        st_mie  <= csr_new[3];
                        st_mpie <= csr_new[7];
                        st_mpp  <= (csr_new[12:11] == 2'b11) ? 2'b11 : 2'b00;
                     end
                     A_MIE: mie_r <= csr_new & IRQ_MASK;
                     A_MTVEC: begin
                        mtvec_base <= csr_new[XLEN-1:2];
                        mtvec_mode <= (csr_new[1:0] == 2'b01);
                     end
                     A_MSCRATCH: mscratch <= csr_new;
                     A_MEPC:     mepc     <= {csr_new[XLEN-1:2], 2'b00};
                     A_MCAUSE:   mcause   <= csr_new;
                     A_MTVAL:    mtval    <= csr_new;
                     A_MCYCLE:   mcycle   <= csr_new;
                     A_MINSTRET: minstret <= csr_new;
                     default: ;
                  endcase
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_csr_trap_unit.sv
// Bench for csr_trap_unit: directed scenarios with literal expectations, then random commits
// compared every cycle against an architectural model of the machine CSRs.
module tb_csr_trap_unit;

   localparam int NIRQ = 4;

   logic            clk, reset;
   logic [11:0]     ra;
   logic [63:0]     rd;
   logic            commit_valid;
   logic [63:0]     commit_pc;
   logic [2:0]      commit_kind;
   logic [11:0]     commit_csr;
   logic [63:0]     commit_wdata;
   logic [2:0]      commit_exc;
   logic [63:0]     commit_tval;
   logic            stall;
   logic            irq_timer, irq_soft, irq_ext;
   logic [NIRQ-1:0] irq_plat;
   logic            redirect;
   logic [63:0]     redirect_pc;
   logic [1:0]      priv;

   csr_trap_unit #(
      .XLEN(64), .NIRQ(NIRQ), .SYNC_IRQ(1), .RESET_VEC(64'h8000_0000), .HART_ID(64'h0)
   ) dut (
      .clk(clk), .reset(reset), .ra(ra), .rd(rd),
      .commit_valid(commit_valid), .commit_pc(commit_pc), .commit_kind(commit_kind),
      .commit_csr(commit_csr), .commit_wdata(commit_wdata), .commit_exc(commit_exc),
      .commit_tval(commit_tval), .stall(stall),
      .irq_timer(irq_timer), .irq_soft(irq_soft), .irq_ext(irq_ext), .irq_plat(irq_plat),
      .redirect(redirect), .redirect_pc(redirect_pc), .priv(priv)
   );

   int checks = 0;
   int errors = 0;
   int cycle  = 0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s at cycle %0d: got %h, expected %h", name, cycle, actual, expected);
      end
   endtask

   // Architectural model: whole CSR words, with mip seen two sampling edges after the lines.
   logic [63:0] m_mstatus, m_mie, m_mtvec, m_mscratch, m_mepc, m_mcause, m_mtval;
   logic [63:0] m_mcycle, m_minstret;
   logic [1:0]  m_priv;
   logic [63:0] lineHist [0:1];
   bit          modelValid = 0;
   int          prio [7] = '{11, 3, 7, 16, 17, 18, 19};

   function automatic logic [63:0] linesAsMip();
      logic [63:0] w;
      w = '0;
      w[3]  = irq_soft;
      w[7]  = irq_timer;
      w[11] = irq_ext;
      for (int i = 0; i < NIRQ; i++) w[16+i] = irq_plat[i];
      return w;
   endfunction

   function automatic logic [63:0] mread(input logic [11:0] a);
      case (a)
         12'h300: return m_mstatus;
         12'h304: return m_mie;
         12'h344: return lineHist[1];
         12'h305: return m_mtvec;
         12'h340: return m_mscratch;
         12'h341: return m_mepc;
         12'h342: return m_mcause;
         12'h343: return m_mtval;
         12'hB00: return m_mcycle;
         12'hB02: return m_minstret;
         default: return 64'h0;
      endcase
   endfunction

   function automatic void mwrite(input logic [11:0] a, input logic [63:0] v);
      case (a)
         12'h300: m_mstatus  = (v & 64'h88) | ((v[12:11] == 2'b11) ? 64'h1800 : 64'h0);
         12'h304: m_mie      = v & 64'hF_0888;
         12'h305: m_mtvec    = (v & ~64'h3) | ((v[1:0] == 2'b01) ? 64'h1 : 64'h0);
         12'h340: m_mscratch = v;
         12'h341: m_mepc     = v & ~64'h3;
         12'h342: m_mcause   = v;
         12'h343: m_mtval    = v;
         12'hB00: m_mcycle   = v;
         12'hB02: m_minstret = v;
         default: ;
      endcase
   endfunction

   logic [63:0] cPend, cExpPc, cOld, cNew, cCause, cTval;
   logic        cActive, cExc, cIrq, cCsr, cMret, cRedir, cRetire;
   int          cPick;

   // Compare the current cycle, then advance the model to what the next edge must produce.
   always @(negedge clk) begin
      cycle++;
      if (modelValid) begin
         checkOutput("rd", rd, mread(ra));
         checkOutput("priv", 64'(priv), 64'(m_priv));
      end
      cActive = commit_valid && !stall;
      cPend   = lineHist[1] & m_mie;
      cExc    = cActive && (commit_exc != 3'd0 || commit_kind == 3'd5);
      cIrq    = cActive && !cExc && m_mstatus[3] && (cPend != 64'h0);
      cCsr    = cActive && !cExc && !cIrq && commit_kind >= 3'd1 && commit_kind <= 3'd3;
      cMret   = cActive && !cExc && !cIrq && commit_kind == 3'd4;
      cRetire = cActive && !cExc && !cIrq;
      cRedir  = cExc || cIrq || cCsr || cMret;
      cExpPc  = 64'h0;
      cCause  = 64'h0;
      cTval   = 64'h0;
      cOld    = mread(commit_csr);
      cNew    = commit_wdata;
      if (cExc) begin
         if (commit_exc != 3'd0) begin
            cCause = 64'(2 * (int'(commit_exc) - 1));
            cTval  = commit_tval;
         end else begin
            cCause = (m_priv == 2'd3) ? 64'd11 : 64'd8;
         end
         cExpPc = m_mtvec & ~64'h3;
      end else if (cIrq) begin
         cPick = 0;
         for (int i = 6; i >= 0; i--) if (cPend[prio[i]]) cPick = prio[i];
         cCause = 64'h8000_0000_0000_0000 | 64'(cPick);
         cExpPc = (m_mtvec & ~64'h3) + ((m_mtvec[1:0] == 2'b01) ? 64'(4 * cPick) : 64'h0);
      end else if (cCsr) begin
         if (commit_kind == 3'd2) cNew = cOld | commit_wdata;
         if (commit_kind == 3'd3) cNew = cOld & ~commit_wdata;
         cExpPc = commit_pc + 64'd4;
      end else if (cMret) begin
         cExpPc = m_mepc;
      end
      if (modelValid && !reset) begin
         checkOutput("redirect", 64'(redirect), 64'(cRedir));
         if (cRedir) checkOutput("redirect_pc", redirect_pc, cExpPc);
      end

      if (reset) begin
         m_mstatus = 0; m_mie = 0; m_mscratch = 0; m_mepc = 0; m_mcause = 0; m_mtval = 0;
         m_mcycle = 0; m_minstret = 0; m_priv = 2'd3; m_mtvec = 64'h8000_0000;
         lineHist[0] = 0; lineHist[1] = 0;
         modelValid = 1;
      end else begin
         m_mcycle = m_mcycle + 1;
         if (cRetire) m_minstret = m_minstret + 1;
         if (cExc || cIrq) begin
            m_mepc    = commit_pc & ~64'h3;
            m_mcause  = cCause;
            m_mtval   = cTval;
            m_mstatus = (m_mstatus[3] ? 64'h80 : 64'h0) | ((m_priv == 2'd3) ? 64'h1800 : 64'h0);
            m_priv    = 2'd3;
         end else if (cCsr) begin
            if (commit_kind == 3'd1 || commit_wdata != 64'h0) mwrite(commit_csr, cNew);
         end else if (cMret) begin
            m_priv    = m_mstatus[12:11];
            m_mstatus = (m_mstatus[7] ? 64'h8 : 64'h0) | 64'h80;
         end
         lineHist[1] = lineHist[0];
         lineHist[0] = linesAsMip();
      end
   end

   task automatic applyStimulus(input logic v, input logic [2:0] k, input logic [11:0] csr,
                                input logic [63:0] wd, input logic [2:0] exc, input logic [63:0] tval,
                                input logic [63:0] pc, input logic st, input logic [11:0] rad);
      @(posedge clk);
      #1;
      commit_valid = v;  commit_kind = k;  commit_csr = csr; commit_wdata = wd;
      commit_exc   = exc; commit_tval = tval; commit_pc = pc; stall = st; ra = rad;
      #1;
   endtask

   task automatic idle(input logic [11:0] rad);
      applyStimulus(1'b0, 3'd0, 12'h0, 64'h0, 3'd0, 64'h0, 64'h0, 1'b0, rad);
   endtask

   task automatic csrOp(input logic [2:0] k, input logic [11:0] csr, input logic [63:0] wd,
                        input logic [63:0] pc, input logic [11:0] rad);
      applyStimulus(1'b1, k, csr, wd, 3'd0, 64'h0, pc, 1'b0, rad);
   endtask

   logic [11:0] csrList [12] = '{12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342,
                                  12'h343, 12'h344, 12'hB00, 12'hB02, 12'hF14, 12'h7C0};

   initial begin
      reset = 1'b1; commit_valid = 0; commit_pc = 0; commit_kind = 0; commit_csr = 0;
      commit_wdata = 0; commit_exc = 0; commit_tval = 0; stall = 0; ra = 12'h305;
      irq_timer = 0; irq_soft = 0; irq_ext = 0; irq_plat = '0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;

      idle(12'h305);  checkOutput("reset_mtvec", rd, 64'h8000_0000);
      checkOutput("reset_priv", 64'(priv), 64'd3);
      idle(12'h300);  checkOutput("reset_mstatus", rd, 64'h0);
      idle(12'hB00);  checkOutput("mcycle_after_3", rd, 64'd3);

      csrOp(3'd1, 12'h305, 64'h100, 64'h40, 12'h305);
      checkOutput("csrrw_redirect", 64'(redirect), 64'd1);
      checkOutput("csrrw_target", redirect_pc, 64'h44);
      checkOutput("no_bypass", rd, 64'h8000_0000);
      idle(12'h305);  checkOutput("mtvec_written", rd, 64'h100);
      csrOp(3'd2, 12'h300, 64'h0, 64'h48, 12'h300);
      checkOutput("csrrs0_target", redirect_pc, 64'h4C);
      idle(12'h300);  checkOutput("csrrs0_nochange", rd, 64'h0);

      applyStimulus(1'b1, 3'd4, 12'h0, 64'h0, 3'd0, 64'h0, 64'h50, 1'b0, 12'h300);
      checkOutput("mret_target", redirect_pc, 64'h0);
      idle(12'h300);  checkOutput("mret_priv_u", 64'(priv), 64'd0);
      applyStimulus(1'b1, 3'd5, 12'h0, 64'h0, 3'd0, 64'h0, 64'h200, 1'b0, 12'h342);
      checkOutput("ecall_target", redirect_pc, 64'h100);
      idle(12'h342);  checkOutput("ecall_u_cause", rd, 64'd8);
      checkOutput("ecall_priv_m", 64'(priv), 64'd3);
      idle(12'h341);  checkOutput("ecall_mepc", rd, 64'h200);
      idle(12'h300);  checkOutput("ecall_mpp_u", rd & 64'h1800, 64'h0);

      csrOp(3'd1, 12'h305, 64'h101, 64'h54, 12'h0);
      csrOp(3'd1, 12'h304, 64'h4_0000, 64'h58, 12'h0);
      csrOp(3'd1, 12'h300, 64'h8, 64'h5C, 12'h0);
      irq_plat = 4'b0100;
      csrOp(3'd0, 12'h0, 64'h0, 64'h60, 12'h0);
      checkOutput("irq_sync_not_early", 64'(redirect), 64'd0);
      csrOp(3'd0, 12'h0, 64'h0, 64'h64, 12'h0);
      checkOutput("irq_taken", 64'(redirect), 64'd1);
      checkOutput("irq_vectored_pc", redirect_pc, 64'h148);
      irq_plat = 4'b0000;
      idle(12'h342);  checkOutput("irq_mcause", rd, 64'h8000_0000_0000_0012);
      idle(12'h300);  checkOutput("irq_mstatus", rd, 64'h1880);

      irq_ext = 1'b1;
      csrOp(3'd1, 12'h304, 64'h800, 64'h70, 12'h0);
      idle(12'h0);
      idle(12'h0);
      csrOp(3'd1, 12'h300, 64'h8, 64'h74, 12'h0);
      applyStimulus(1'b1, 3'd1, 12'h340, 64'hDEAD, 3'd3, 64'h1234_5677, 64'h300, 1'b0, 12'h340);
      checkOutput("exc_over_irq_pc", redirect_pc, 64'h100);
      irq_ext = 1'b0;
      idle(12'h342);  checkOutput("exc_mcause", rd, 64'd4);
      idle(12'h343);  checkOutput("exc_mtval", rd, 64'h1234_5677);
      idle(12'h340);  checkOutput("exc_csr_unchanged", rd, 64'h0);

      irq_timer = 1'b1;
      csrOp(3'd1, 12'hB02, 64'h0, 64'h80, 12'h0);
      csrOp(3'd1, 12'h304, 64'h80, 64'h84, 12'h0);
      csrOp(3'd1, 12'h300, 64'h8, 64'h88, 12'h0);
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b1, 3'd0, 12'h0, 64'h0, 3'd0, 64'h0, 64'h8C, 1'b1, 12'hB02);
         checkOutput("stall_no_redirect", 64'(redirect), 64'd0);
         checkOutput("stall_minstret", rd, 64'd2);
      end
      applyStimulus(1'b1, 3'd0, 12'h0, 64'h0, 3'd0, 64'h0, 64'h90, 1'b0, 12'hB02);
      checkOutput("unstall_irq_pc", redirect_pc, 64'h11C);
      irq_timer = 1'b0;
      idle(12'hB02);  checkOutput("trap_no_retire", rd, 64'd2);
      idle(12'h342);  checkOutput("timer_mcause", rd, 64'h8000_0000_0000_0007);

      for (int n = 0; n < 4000; n++) begin
         int r;
         logic [2:0]  k;
         logic [63:0] wd;
         r = int'($urandom_range(0, 15));
         k = (r <= 4 || r >= 14) ? 3'd0 : (r <= 7) ? 3'd1 : (r <= 9) ? 3'd2 :
             (r <= 11) ? 3'd3 : (r == 12) ? 3'd4 : 3'd5;
         wd = ($urandom_range(0, 3) == 0) ? 64'h0 : {$urandom, $urandom};
         reset = ($urandom_range(0, 199) == 0);
         if ($urandom_range(0, 7) == 0) irq_timer = ~irq_timer;
         if ($urandom_range(0, 7) == 0) irq_soft  = ~irq_soft;
         if ($urandom_range(0, 7) == 0) irq_ext   = ~irq_ext;
         if ($urandom_range(0, 7) == 0) irq_plat[$urandom_range(0, NIRQ-1)] ^= 1'b1;
         applyStimulus($urandom_range(0, 9) < 8, k, csrList[$urandom_range(0, 11)], wd,
                       ($urandom_range(0, 9) == 0) ? 3'($urandom_range(1, 4)) : 3'd0,
                       {$urandom, $urandom}, {$urandom, $urandom},
                       $urandom_range(0, 9) < 2, csrList[$urandom_range(0, 11)]);
      end
      reset = 1'b0;
      idle(12'h0);
      idle(12'h0);
      @(negedge clk);
      #1;
      $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
      $finish;
   end

endmodule
